// File: rtl/spi_pkg.sv
// Shared definitions for the SPI/APB front-end blocks.
//   SPI_ADDR_W / SPI_DATA_W : default APB address and data widths
//   apb_state_e             : APB master phase (IDLE / SETUP / ACCESS)
package spi_pkg;

  localparam int SPI_ADDR_W = 5;
  localparam int SPI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector, bit n = requester n
//   update   : record the current grant as "last granted"
//   gnt      : one-hot combinational grant (0 when req is 0)
// The last-granted pointer resets to 1, so requester 0 wins the first tie.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last;

  // A single requester always wins; on a tie the one not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update && (|gnt)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/spi_apb_arb.sv
// Two-requester APB arbiter in front of a single spi_apb slave.
//   pclk, preset          : clock, asynchronous active-high reset
//   s0_* / s1_*           : APB slave ports of requesters 0 and 1
//   m_*                   : APB master port towards the spi_apb instance
//   gnt                   : one-hot current grant, 0 when idle
// A requester is granted on psel alone; its address, data and direction are
// latched at grant and held until the master transfer completes. The
// response is passed through combinationally to the granted requester only,
// and only if it kept psel asserted for the whole transfer.
module spi_apb_arb
  import spi_pkg::*;
#(
  parameter int addr_w = SPI_ADDR_W,
  parameter int data_w = SPI_DATA_W
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [addr_w-1:0] s0_paddr,
  input  logic [data_w-1:0] s0_pwdata,
  input  logic              s0_psel,
  input  logic              s0_penable,
  input  logic              s0_pwrite,
  output logic [data_w-1:0] s0_prdata,
  output logic              s0_pready,
  output logic              s0_pslverr,
  input  logic [addr_w-1:0] s1_paddr,
  input  logic [data_w-1:0] s1_pwdata,
  input  logic              s1_psel,
  input  logic              s1_penable,
  input  logic              s1_pwrite,
  output logic [data_w-1:0] s1_prdata,
  output logic              s1_pready,
  output logic              s1_pslverr,
  output logic [addr_w-1:0] m_paddr,
  output logic [data_w-1:0] m_pwdata,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  input  logic [data_w-1:0] m_prdata,
  input  logic              m_pready,
  input  logic              m_pslverr,
  output logic [1:0]        gnt
);

  apb_state_e        state, state_nxt;
  logic [1:0]        psel, arb_req, arb_gnt, gnt_q;
  logic              load, done, drop_q;
  logic [addr_w-1:0] addr_q;
  logic [data_w-1:0] wdata_q;
  logic              write_q;

  // penable is irrelevant to request detection.
  logic unused_penable;
  assign unused_penable = s0_penable ^ s1_penable;

  assign psel = {s1_psel, s0_psel};
  assign done = (state == ACCESS) && m_pready;

  spi_rr_arb2 u_arb (
    .clk    (pclk),
    .rst    (preset),
    .req    (arb_req),
    .update (load),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On completion the finishing requester is masked out, so only the other
  // one can be granted straight into SETUP.
  always_comb begin
    state_nxt = state;
    arb_req   = 2'b00;
    load      = 1'b0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    case (state)
      IDLE: begin
        arb_req = psel;
        if (|psel) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        m_psel    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        if (m_pready) begin
          arb_req = psel & ~gnt_q;
          if (|arb_req) begin
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // drop_q remembers that the granted requester let go of psel, so its
  // transfer finishes on the master side but is never acknowledged.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gnt_q  <= 2'b00;
      drop_q <= 1'b0;
    end else if (load) begin
      gnt_q  <= arb_gnt;
      drop_q <= 1'b0;
    end else if (done) begin
      gnt_q  <= 2'b00;
    end else if ((state != IDLE) && !(|(psel & gnt_q))) begin
      drop_q <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (load) begin
      addr_q  <= arb_gnt[1] ? s1_paddr  : s0_paddr;
      wdata_q <= arb_gnt[1] ? s1_pwdata : s0_pwdata;
      write_q <= arb_gnt[1] ? s1_pwrite : s0_pwrite;
    end
  end

  // Latched fields are only visible while a transfer is on the bus.
  assign m_paddr  = m_psel ? addr_q  : '0;
  assign m_pwdata = m_psel ? wdata_q : '0;
  assign m_pwrite = m_psel & write_q;
  assign gnt      = gnt_q;

  assign s0_pready  = done & gnt_q[0] & s0_psel & ~drop_q;
  assign s1_pready  = done & gnt_q[1] & s1_psel & ~drop_q;
  assign s0_prdata  = s0_pready ? m_prdata : '0;
  assign s1_prdata  = s1_pready ? m_prdata : '0;
  assign s0_pslverr = s0_pready & m_pslverr;
  assign s1_pslverr = s1_pready & m_pslverr;

endmodule

// File: tb/tb_spi_apb_arb.sv
module tb_spi_apb_arb;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic [AW-1:0] s0_paddr, s1_paddr, m_paddr;
  logic [DW-1:0] s0_pwdata, s1_pwdata, m_pwdata;
  logic          s0_psel, s0_penable, s0_pwrite, s1_psel, s1_penable, s1_pwrite;
  logic [DW-1:0] s0_prdata, s1_prdata, m_prdata;
  logic          s0_pready, s0_pslverr, s1_pready, s1_pslverr;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [1:0]    gnt;

  always #5 pclk = ~pclk;

  spi_apb_arb #(.addr_w(AW), .data_w(DW)) dut (
    .pclk(pclk), .preset(preset),
    .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_psel(s0_psel),
    .s0_penable(s0_penable), .s0_pwrite(s0_pwrite), .s0_prdata(s0_prdata),
    .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
    .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_psel(s1_psel),
    .s1_penable(s1_penable), .s1_pwrite(s1_pwrite), .s1_prdata(s1_prdata),
    .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_psel(m_psel),
    .m_penable(m_penable), .m_pwrite(m_pwrite), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .gnt(gnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master-side responder: m_pready after wait_cfg ACCESS cycles.
  int            wait_cfg   = 0;
  logic [DW-1:0] rdata_cfg  = '0;
  logic          slverr_cfg = 1'b0;
  int            acc_cnt    = 0;

  always @(posedge pclk) begin
    if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign m_pready  = m_psel && m_penable && (acc_cnt >= wait_cfg);
  assign m_prdata  = rdata_cfg;
  assign m_pslverr = slverr_cfg;

  // Scoreboard: one expected-transfer queue per requester, pushed when the
  // request is driven and popped when the master enters SETUP for it.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
  } xact_t;

  xact_t q0[$];
  xact_t q1[$];
  int    gnt_log[$];
  xact_t e_mon;
  xact_t su;
  logic [1:0] su_gnt = 2'b00;

  always @(negedge pclk) begin
    if (!(gnt[0] && m_penable && m_pready))
      chk("s0_quiet", {s0_pready, s0_pslverr, s0_prdata}, 64'd0);
    if (!(gnt[1] && m_penable && m_pready))
      chk("s1_quiet", {s1_pready, s1_pslverr, s1_prdata}, 64'd0);
    if (s0_pready) chk("s0_passthru", {s0_pslverr, s0_prdata}, {m_pslverr, m_prdata});
    if (s1_pready) chk("s1_passthru", {s1_pslverr, s1_prdata}, {m_pslverr, m_prdata});
    if (!m_psel) chk("idle_gnt", {m_penable, gnt}, 64'd0);
    if (m_psel && !m_penable) begin
      chk("setup_onehot", {63'd0, $onehot(gnt)}, 64'd1);
      gnt_log.push_back(gnt[1] ? 1 : 0);
      if ((gnt[1] && q1.size() == 0) || (!gnt[1] && q0.size() == 0)) begin
        chk("sb_unexpected_grant", {62'd0, gnt}, 64'd0);
      end else begin
        e_mon = gnt[1] ? q1.pop_front() : q0.pop_front();
        chk("sb_addr",  m_paddr,  e_mon.a);
        chk("sb_wdata", m_pwdata, e_mon.d);
        chk("sb_write", m_pwrite, e_mon.w);
      end
      su.a = m_paddr; su.d = m_pwdata; su.w = m_pwrite; su_gnt = gnt;
    end
    if (m_psel && m_penable)
      chk("access_stable", {gnt, m_pwrite, m_paddr, m_pwdata}, {su_gnt, su.w, su.a, su.d});
  end

  task automatic drive(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xact_t x;
    x.a = a; x.d = d; x.w = w;
    if (n == 0) begin
      q0.push_back(x);
      s0_paddr = a; s0_pwdata = d; s0_pwrite = w; s0_psel = 1'b1; s0_penable = 1'b1;
    end else begin
      q1.push_back(x);
      s1_paddr = a; s1_pwdata = d; s1_pwrite = w; s1_psel = 1'b1; s1_penable = 1'b1;
    end
  endtask

  task automatic release_sel(input int n);
    if (n == 0) begin s0_psel = 1'b0; s0_penable = 1'b0; end
    else begin s1_psel = 1'b0; s1_penable = 1'b0; end
  endtask

  // One full transfer from requester n; lat = cycles from request to pready.
  task automatic xfer(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic err, output int lat);
    bit found = 0;
    drive(n, w, a, d);
    lat = 0; rd = '0; err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if ((n == 0) ? s0_pready : s1_pready) begin
        rd  = (n == 0) ? s0_prdata  : s1_prdata;
        err = (n == 0) ? s0_pslverr : s1_pslverr;
        found = 1;
        break;
      end
      lat++;
    end
    if (!found) chk("xfer_timeout", 64'd0, 64'd1);
    @(posedge pclk); #1;
    release_sel(n);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_master", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 64'd0);
    chk("rst_gnt", {62'd0, gnt}, 64'd0);
    chk("rst_slaves", {s0_pready, s0_pslverr, s1_pready, s1_pslverr, s0_prdata, s1_prdata}, 64'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
  endtask

  typedef struct {
    int            n;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rdat;
    logic          serr;
    int            waits;
  } vec_t;

  vec_t          vt[6];
  logic [DW-1:0] rd0, rd1;
  logic          er0, er1;
  int            l0, l1;
  bit            ok, saw_rdy, saw_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    s0_paddr = '0; s0_pwdata = '0; s0_psel = 0; s0_penable = 0; s0_pwrite = 0;
    s1_paddr = '0; s1_pwdata = '0; s1_psel = 0; s1_penable = 0; s1_pwrite = 0;

    //            n  w     addr   wdata          rdata          serr  waits
    vt[0] = '{0, 1'b1, 5'h04, 32'h0000_00A5, 32'h0000_0000, 1'b0, 0};
    vt[1] = '{1, 1'b0, 5'h1F, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0};
    vt[2] = '{0, 1'b0, 5'h00, 32'h0000_0000, 32'h1234_5678, 1'b1, 1};
    vt[3] = '{1, 1'b1, 5'h0C, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1, 3};
    vt[4] = '{1, 1'b0, 5'h10, 32'h0000_0000, 32'h8000_0001, 1'b0, 0};
    vt[5] = '{0, 1'b1, 5'h1F, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b0, 2};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      wait_cfg = vt[i].waits; rdata_cfg = vt[i].rdat; slverr_cfg = vt[i].serr;
      xfer(vt[i].n, vt[i].w, vt[i].a, vt[i].d, rd0, er0, l0);
      chk("vec_prdata",  rd0, vt[i].rdat);
      chk("vec_pslverr", er0, vt[i].serr);
      chk("vec_latency", l0, 2 + vt[i].waits);
    end
    wait_cfg = 0; slverr_cfg = 1'b0;

    // Tie straight after reset: s0 first, s1 follows with no idle gap.
    do_reset();
    gnt_log.delete();
    rdata_cfg = 32'h0BAD_CAFE;
    fork
      xfer(0, 1'b1, 5'h08, 32'h1111_2222, rd0, er0, l0);
      xfer(1, 1'b0, 5'h0C, 32'h0000_0000, rd1, er1, l1);
    join
    chk("tie_grants", gnt_log.size(), 2);
    chk("tie_first",  (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);
    chk("tie_lat_s0", l0, 2);
    chk("tie_lat_s1", l1, 4);
    chk("tie_s1_rdata", rd1, 32'h0BAD_CAFE);

    // Fairness under continuous back-to-back requests.
    gnt_log.delete();
    fork
      for (int i = 0; i < 5; i++) begin
        logic [DW-1:0] r; logic e; int l;
        xfer(0, 1'b1, AW'(i), 32'hA000_0000 + i, r, e, l);
      end
      for (int j = 0; j < 5; j++) begin
        logic [DW-1:0] r; logic e; int l;
        xfer(1, 1'b1, AW'(16 + j), 32'hB000_0000 + j, r, e, l);
      end
    join
    chk("fair_count", gnt_log.size(), 10);
    for (int i = 0; i < gnt_log.size(); i++) chk("fair_alternate", gnt_log[i], i % 2);

    // Reset in the middle of an s1 ACCESS phase.
    wait_cfg = 5;
    @(posedge pclk); #1;
    drive(1, 1'b1, 5'h07, 32'h7777_7777);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (m_penable && gnt[1]) begin ok = 1; break; end
    end
    chk("midrst_reached_access", ok, 1);
    preset = 1'b1;
    #1;
    chk("midrst_master", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 64'd0);
    chk("midrst_gnt_slv", {gnt, s0_pready, s1_pready, s1_prdata}, 64'd0);
    release_sel(1);
    @(posedge pclk); #1;
    preset = 1'b0;
    wait_cfg = 0;
    rdata_cfg = 32'h5555_AAAA;
    xfer(1, 1'b0, 5'h03, 32'h0, rd1, er1, l1);
    chk("postrst_s1_lat", l1, 2);
    chk("postrst_s1_rdata", rd1, 32'h5555_AAAA);
    do_reset();
    gnt_log.delete();
    fork
      xfer(0, 1'b0, 5'h01, 32'h0, rd0, er0, l0);
      xfer(1, 1'b0, 5'h02, 32'h0, rd1, er1, l1);
    join
    chk("postrst_tie_first", (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);

    // s1 abandons its request during SETUP.
    wait_cfg = 1;
    drive(1, 1'b1, 5'h1A, 32'hFEED_0001);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (m_psel && !m_penable && gnt[1]) begin ok = 1; break; end
    end
    chk("abandon_reached_setup", ok, 1);
    release_sel(1);
    saw_rdy = 0; saw_done = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (s1_pready) saw_rdy = 1;
      if (m_penable && m_pready) saw_done = 1;
      if (!m_psel) begin ok = 1; break; end
    end
    chk("abandon_returned_idle", ok, 1);
    chk("abandon_master_done", saw_done, 1);
    chk("abandon_no_pready", saw_rdy, 0);
    chk("abandon_idle_gnt", {62'd0, gnt}, 64'd0);
    wait_cfg = 0;

    repeat (2) @(negedge pclk);
    chk("sb_q0_drained", q0.size(), 0);
    chk("sb_q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_apb_arb.md
SPI_APB_ARB -- requirements
Module: spi_apb_arb

Interface
REQ-001 The block SHALL have parameter addr_w, default 5, meaning APB address width on all ports.
REQ-002 The block SHALL have parameter data_w, default 32, meaning APB data width on all ports.
REQ-003 The block SHALL have ports pclk  in  1  clock; preset  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have, for each slave port n in {0,1}: sn_paddr in addr_w; sn_pwdata in data_w; sn_psel in 1; sn_penable in 1; sn_pwrite in 1; sn_prdata out data_w; sn_pready out 1; sn_pslverr out 1. These are the requester n APB slave side.
REQ-005 The block SHALL have master port m_paddr out addr_w; m_pwdata out data_w; m_psel out 1; m_penable out 1; m_pwrite out 1; m_prdata in data_w; m_pready in 1; m_pslverr in 1. This port connects to one spi_apb instance.
REQ-006 The block SHALL have output gnt  2  one-hot current grant, 0 when idle.

Function
REQ-007 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-008 A request from slave n SHALL be sn_psel=1, independent of sn_penable.
REQ-009 In IDLE with at least one request, the FSM SHALL grant one requester, latch its paddr/pwdata/pwrite, and enter SETUP next cycle.
REQ-010 Arbitration SHALL be round-robin: the requester not granted last wins a tie. A sole requester always wins.
REQ-011 In SETUP the outputs SHALL be m_psel=1 and m_penable=0, with latched address, data and write. The FSM SHALL always enter ACCESS next cycle.
REQ-012 In ACCESS the outputs SHALL be m_psel=1 and m_penable=1. The FSM SHALL hold until m_pready=1.
REQ-013 In the ACCESS cycle with m_pready=1, the granted slave SHALL see sn_pready=1, with sn_prdata=m_prdata and sn_pslverr=m_pslverr, passed through combinationally.
REQ-014 At all other times and for the non-granted slave: sn_pready=0, sn_prdata=0, sn_pslverr=0.
REQ-015 On completion, if the other slave requests, the block SHALL grant it and enter SETUP next cycle. Otherwise it SHALL enter IDLE.
REQ-016 The completing slave SHALL NOT be re-granted in the completion cycle. A back-to-back request from it SHALL be sampled from the following cycle.
REQ-017 Minimum latency SHALL be: request at cycle 0 in IDLE -> SETUP at cycle 1 -> ACCESS and sn_pready at cycle 2 (spi_apb asserts pready=penable).
REQ-018 If the granted slave drops psel mid-transfer, the master transfer SHALL still complete. The result SHALL be discarded and sn_pready SHALL stay 0.
REQ-019 A write from one slave SHALL never reach the master with the other slave's address or data. Latched values SHALL be held from grant to completion.
REQ-020 gnt SHALL equal the latched grant in SETUP and ACCESS, and 0 in IDLE.

Reset
REQ-021 While preset=1, the block SHALL asynchronously be in IDLE, with all m_* outputs 0, gnt=0, and all sn_* outputs 0.
REQ-022 The last-grant pointer SHALL reset to 1, so slave 0 has first priority.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer immediately, with no pready to either slave. After release the FSM SHALL start from IDLE.

Structure
REQ-024 The state enum (IDLE/SETUP/ACCESS) SHALL reside in the shared spi package, together with the default widths 5/32.
REQ-025 A sub-module spi_rr_arb2 SHALL hold the 2-way round-robin grant logic and pointer. The FSM and datapath latches SHALL stay in spi_apb_arb.

Verification
REQ-026 Single write: s0 writes addr 0x04, data 0xA5 -> m_psel=1 at cycle 1, m_penable=1 at cycle 2, s0_pready=1 at cycle 2, s1_pready=0.
REQ-027 Simultaneous request after reset: s0 writes 0x08 and s1 reads 0x0C -> s0 served first. s1 goes to SETUP in the cycle after s0 completes with no IDLE gap, and s1_prdata equals m_prdata at its completion.
REQ-028 Fairness: both hold continuous back-to-back requests for 10 transfers -> grants alternate 0,1,0,1 and neither starves.
REQ-029 Wait states: m_pready held low 3 cycles in ACCESS -> master signals stable, granted pready low until m_pready=1, m_pslverr=1 forwarded only to the granted slave.
REQ-030 Reset mid-ACCESS: assert preset while s1 is granted -> all outputs 0 the same cycle. After release an s1 request is served normally and s0 has priority on a tie.
REQ-031 Abandoned request: s1 drops psel during SETUP -> master completes, s1_pready never asserts, FSM returns to IDLE.
